// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Inputs : clk, reset (sync, active-low), OPCODE_EX/FUNCT3_EX/FUNCT7_EX,
//          REG_DATA1_EX/REG_DATA2_EX (rs1/rs2), RD_EX, flush.
// Outputs: MDU_STALL (comb), MDU_DONE strobe, MDU_RESULT, MDU_RD.
module ex_muldiv_unit #(
   parameter int unsigned WIDTH    = 32,
   parameter logic [6:0]  OP_RTYPE = 7'b0110011,
   parameter logic [6:0]  FUNCT7_M = 7'b0000001
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       OPCODE_EX,
   input  logic [2:0]       FUNCT3_EX,
   input  logic [6:0]       FUNCT7_EX,
   input  logic [WIDTH-1:0] REG_DATA1_EX,
   input  logic [WIDTH-1:0] REG_DATA2_EX,
   input  logic [4:0]       RD_EX,
   input  logic             flush,
   output logic             MDU_STALL,
   output logic             MDU_DONE,
   output logic [WIDTH-1:0] MDU_RESULT,
   output logic [4:0]       MDU_RD
);

   localparam int unsigned W = WIDTH;
   localparam logic [5:0] LAST = 6'(W - 1);
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state_q;
   logic [5:0]     cnt_q;
   logic [2:0]     f3_q;
   logic [4:0]     rd_q;
   logic [W-1:0]   op_q;
   logic [W-1:0]   rs1_q;
   logic [2*W-1:0] p_q;
   logic [2*W-1:0] p_d;
   logic           neg_q;
   logic           dz_q;
   logic           ovf_q;
   logic           done_q;
   logic [W-1:0]   res_q;
   logic [4:0]     rdo_q;

   logic           is_m;
   logic           s1_sig;
   logic           s2_sig;
   logic           sa;
   logic           sb;
   logic [W-1:0]   abs1;
   logic [W-1:0]   abs2;
   logic           neg_d;
   logic           dz_d;
   logic           ovf_d;

   assign is_m = (OPCODE_EX == OP_RTYPE) && (FUNCT7_EX == FUNCT7_M);

   // Signed rs1: MUL/MULH/MULHSU/DIV/REM. Signed rs2: same minus MULHSU.
   assign s1_sig = !(FUNCT3_EX[0] && (FUNCT3_EX[1] || FUNCT3_EX[2]));
   assign s2_sig = s1_sig && (FUNCT3_EX != 3'd2);
   assign sa     = s1_sig && REG_DATA1_EX[W-1];
   assign sb     = s2_sig && REG_DATA2_EX[W-1];
   assign abs1   = sa ? -REG_DATA1_EX : REG_DATA1_EX;
   assign abs2   = sb ? -REG_DATA2_EX : REG_DATA2_EX;

   // Remainder follows the dividend; everything else follows s1^s2.
   assign neg_d = (FUNCT3_EX == 3'd6) ? sa : (sa ^ sb);
   assign dz_d  = FUNCT3_EX[2] && (REG_DATA2_EX == '0);
   assign ovf_d = FUNCT3_EX[2] && !FUNCT3_EX[0]
                  && (REG_DATA1_EX == MIN_NEG)
                  && (REG_DATA2_EX == '1);

   // Multiply: p = {acc, multiplier}, add then shift right.
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_nxt;

   assign mul_sum = {1'b0, p_q[2*W-1:W]}
                  + (p_q[0] ? {1'b0, op_q} : '0);
   assign mul_nxt = {mul_sum, p_q[W-1:1]};

   // Divide: p = {rem, quotient}, shift left then trial subtract.
   logic [W:0]     t;
   logic           ge;
   logic [W-1:0]   sub;
   logic [2*W-1:0] div_nxt;

   assign t   = {p_q[2*W-1:W], p_q[W-1]};
   assign ge  = t >= {1'b0, op_q};
   assign sub = t[W-1:0] - op_q;
   assign div_nxt = ge ? {sub, p_q[W-2:0], 1'b1}
                       : {t[W-1:0], p_q[W-2:0], 1'b0};

   assign p_d = f3_q[2] ? div_nxt : mul_nxt;

   logic [2*W-1:0] prod_s;
   logic [W-1:0]   q_s;
   logic [W-1:0]   r_s;
   logic [W-1:0]   res_d;

   assign prod_s = neg_q ? -p_d : p_d;
   assign q_s    = neg_q ? -p_d[W-1:0] : p_d[W-1:0];
   assign r_s    = neg_q ? -p_d[2*W-1:W] : p_d[2*W-1:W];

   always_comb begin
      res_d = '0;
      if (!f3_q[2]) begin
         res_d = (f3_q[1:0] == 2'b00) ? prod_s[W-1:0]
                                      : prod_s[2*W-1:W];
      end else if (dz_q) begin
         res_d = f3_q[1] ? rs1_q : '1;
      end else if (ovf_q) begin
         res_d = f3_q[1] ? '0 : MIN_NEG;
      end else begin
         res_d = f3_q[1] ? r_s : q_s;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         op_q    <= '0;
         rs1_q   <= '0;
         p_q     <= '0;
         neg_q   <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
         rdo_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            state_q <= IDLE;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (is_m) begin
                     f3_q    <= FUNCT3_EX;
                     rd_q    <= RD_EX;
                     rs1_q   <= REG_DATA1_EX;
                     op_q    <= FUNCT3_EX[2] ? abs2 : abs1;
                     p_q     <= {{W{1'b0}},
                                 FUNCT3_EX[2] ? abs1 : abs2};
                     neg_q   <= neg_d;
                     dz_q    <= dz_d;
                     ovf_q   <= ovf_d;
                     cnt_q   <= '0;
                     state_q <= CALC;
                  end
               end
               CALC: begin
                  p_q   <= p_d;
                  cnt_q <= cnt_q + 6'd1;
                  if (cnt_q == LAST) begin
                     res_q   <= res_d;
                     rdo_q   <= rd_q;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
               DONE: state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // No stall in DONE: ID/EX still holds the finished op and must advance.
   assign MDU_STALL = reset && !flush
                      && ((state_q == IDLE && is_m) || state_q == CALC);
   assign MDU_DONE   = done_q;
   assign MDU_RESULT = res_q;
   assign MDU_RD     = rdo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed checks of ex_muldiv_unit results,
// latency, flush/reset abort and back-to-back issue.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  OPCODE_EX;
   logic [2:0]  FUNCT3_EX;
   logic [6:0]  FUNCT7_EX;
   logic [31:0] REG_DATA1_EX;
   logic [31:0] REG_DATA2_EX;
   logic [4:0]  RD_EX;
   logic        flush;
   logic        MDU_STALL;
   logic        MDU_DONE;
   logic [31:0] MDU_RESULT;
   logic [4:0]  MDU_RD;

   int errs = 0;
   int checks = 0;

   ex_muldiv_unit dut (
      .clk          (clk),
      .reset        (reset),
      .OPCODE_EX    (OPCODE_EX),
      .FUNCT3_EX    (FUNCT3_EX),
      .FUNCT7_EX    (FUNCT7_EX),
      .REG_DATA1_EX (REG_DATA1_EX),
      .REG_DATA2_EX (REG_DATA2_EX),
      .RD_EX        (RD_EX),
      .flush        (flush),
      .MDU_STALL    (MDU_STALL),
      .MDU_DONE     (MDU_DONE),
      .MDU_RESULT   (MDU_RESULT),
      .MDU_RD       (MDU_RD)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_m(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      OPCODE_EX    = 7'b0110011;
      FUNCT7_EX    = 7'b0000001;
      FUNCT3_EX    = f3;
      REG_DATA1_EX = a;
      REG_DATA2_EX = b;
      RD_EX        = rd;
   endtask

   task automatic set_add();
      OPCODE_EX = 7'b0110011;
      FUNCT7_EX = 7'b0000000;
      FUNCT3_EX = 3'd0;
      RD_EX     = 5'd1;
   endtask

   task automatic do_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
      int nst;
      int dcy;
      int npulse;
      logic [31:0] res;
      logic [4:0]  rdo;
      nst = 0;
      dcy = -1;
      npulse = 0;
      res = '0;
      rdo = '0;
      @(posedge clk);
      #1 set_m(f3, a, b, rd);
      for (int c = 0; c < 34; c++) begin
         @(negedge clk);
         if (MDU_STALL) nst++;
         if (MDU_DONE) begin
            npulse++;
            if (dcy < 0) begin
               dcy = c;
               res = MDU_RESULT;
               rdo = MDU_RD;
            end
         end
      end
      @(posedge clk);
      #1 set_add();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (MDU_STALL) nst++;
         if (MDU_DONE) npulse++;
      end
      chk({tag, "_stallcycles"}, nst, 33);
      chk({tag, "_donecycle"}, dcy, 33);
      chk({tag, "_pulses"}, npulse, 1);
      chk({tag, "_result"}, res, exp);
      chk({tag, "_rd"}, {27'b0, rdo}, {27'b0, rd});
   endtask

   initial begin
      int nd;
      int rise;
      int d1;
      int d2;
      int np;
      logic prev;
      logic [31:0] r2;

      // Reset held with an M op present: stall must stay low.
      reset = 1'b0;
      flush = 1'b0;
      set_m(3'd0, 32'd7, 32'd3, 5'd4);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {31'b0, MDU_STALL}, 32'd0);
      chk("rst_done", {31'b0, MDU_DONE}, 32'd0);
      chk("rst_result", MDU_RESULT, 32'd0);
      chk("rst_rd", {27'b0, MDU_RD}, 32'd0);
      @(posedge clk);
      #1 set_add();
      reset = 1'b1;

      do_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB);
      do_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,
            32'hFFFFFFFE);
      do_op("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h0);
      do_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 5'd8, 32'hFFFFFFFF);
      do_op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD);
      do_op("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF);
      do_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11,
            32'h80000000);
      do_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h0);
      do_op("divu_z", 3'd5, 32'd13, 32'd0, 5'd13, 32'hFFFFFFFF);
      do_op("remu_z", 3'd7, 32'd13, 32'd0, 5'd14, 32'd13);
      do_op("div_z", 3'd4, 32'hFFFFFFFB, 32'd0, 5'd15, 32'hFFFFFFFF);
      do_op("rem_z", 3'd6, 32'hFFFFFFFB, 32'd0, 5'd16, 32'hFFFFFFFB);
      do_op("divu", 3'd5, 32'd100, 32'd7, 5'd17, 32'd14);
      do_op("remu", 3'd7, 32'd100, 32'd7, 5'd18, 32'd2);
      do_op("mulhu2", 3'd3, 32'h80000000, 32'd2, 5'd19, 32'd1);

      // Flush at CALC step 10 (cycle 11).
      @(posedge clk);
      #1 set_m(3'd5, 32'd100, 32'd7, 5'd20);
      repeat (11) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      set_add();
      @(negedge clk);
      chk("flush_stall", {31'b0, MDU_STALL}, 32'd0);
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (MDU_DONE || MDU_STALL) nd++;
      end
      chk("flush_nodone", nd, 0);

      // Reset at CALC step 10, instruction still present.
      @(posedge clk);
      #1 set_m(3'd0, 32'd6, 32'd7, 5'd21);
      repeat (11) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_stall", {31'b0, MDU_STALL}, 32'd0);
      chk("midrst_done", {31'b0, MDU_DONE}, 32'd0);
      chk("midrst_result", MDU_RESULT, 32'd0);
      chk("midrst_rd", {27'b0, MDU_RD}, 32'd0);
      @(posedge clk);
      #1 set_add();
      reset = 1'b1;
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (MDU_DONE || MDU_STALL) nd++;
      end
      chk("midrst_nodone", nd, 0);

      // ADD never stalls, then two back-to-back MULs.
      nd = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (MDU_STALL) nd++;
      end
      chk("add_nostall", nd, 0);
      @(posedge clk);
      #1 set_m(3'd0, 32'd6, 32'd7, 5'd22);
      rise = -1;
      d1 = -1;
      d2 = -1;
      np = 0;
      prev = 1'b0;
      r2 = '0;
      for (int c = 0; c < 68; c++) begin
         @(negedge clk);
         if (c > 0 && MDU_STALL && !prev && rise < 0) rise = c;
         prev = MDU_STALL;
         if (MDU_DONE) begin
            np++;
            if (d1 < 0) d1 = c;
            else if (d2 < 0) begin
               d2 = c;
               r2 = MDU_RESULT;
            end
         end
      end
      @(posedge clk);
      #1 set_add();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (MDU_DONE) np++;
      end
      chk("b2b_restart", rise, 34);
      chk("b2b_done1", d1, 33);
      chk("b2b_done2", d2, 67);
      chk("b2b_pulses", np, 2);
      chk("b2b_result", r2, 32'd42);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
